// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks every minterm of an N-input function and
// checks both SoP and PoS implementations against the EXPECT truth table.
module truth_table_sweeper #(
  parameter int N = 2,
  parameter logic [2**N-1:0] EXPECT = 4'b0101,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         f_sop,
  input  logic         f_pos,
  output logic [N-1:0] x_out,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic [N-1:0] first_err_idx,
  output logic         err_valid
);

  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] CNT_LD = CW'(SETTLE);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [N-1:0] X_LAST = {N{1'b1}};
  localparam logic [N:0] ERR_MAX = {1'b1, {N{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  x_q, x_d;
  logic [N:0]    errc_q, errc_d;
  logic [N-1:0]  fidx_q, fidx_d;
  logic          ev_q, ev_d;
  logic          armed_q;
  logic          exp_bit;
  logic          fail;

  // Case inequality so an X/Z from either implementation reads as a miss.
  assign exp_bit = EXPECT[x_q];
  assign fail = (f_sop !== exp_bit) || (f_pos !== exp_bit);

  // Blocks start on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed_q <= 1'b0;
    else        armed_q <= 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      errc_q  <= '0;
      fidx_q  <= '0;
      ev_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      errc_q  <= errc_d;
      fidx_q  <= fidx_d;
      ev_q    <= ev_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    errc_d  = errc_q;
    fidx_d  = fidx_q;
    ev_d    = ev_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start && armed_q) begin
          x_d     = '0;
          errc_d  = '0;
          ev_d    = 1'b0;
          cnt_d   = CNT_LD;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (fail) begin
          if (errc_q != ERR_MAX) errc_d = errc_q + 1'b1;
          if (!ev_q) begin
            fidx_d = x_q;
            ev_d   = 1'b1;
          end
        end
        if (x_q == X_LAST) begin
          state_d = S_DONE;
        end else begin
          x_d     = x_q + 1'b1;
          cnt_d   = CNT_LD;
          state_d = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign x_out         = x_q;
  assign busy          = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done          = (state_q == S_DONE);
  assign pass          = (state_q == S_DONE) && (errc_q == '0);
  assign err_count     = errc_q;
  assign first_err_idx = fidx_q;
  assign err_valid     = ev_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: table vectors, random sweeps against a
// truth-table model, and hand sequences for reset and start corner cases.
module tb_truth_table_sweeper;

  localparam int N = 2;
  localparam int NV = 4;
  localparam int S = 1;
  localparam logic [3:0] EXP = 4'b0101;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       f_sop;
  logic       f_pos;
  logic [1:0] x_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [1:0] first_err_idx;
  logic       err_valid;

  logic [3:0] sop_tab = EXP;
  logic [3:0] pos_tab = EXP;
  int         xinj = -1;
  int         errors = 0;
  int         checks = 0;

  truth_table_sweeper #(.N(N), .EXPECT(EXP), .SETTLE(S)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .f_sop(f_sop),
    .f_pos(f_pos),
    .x_out(x_out),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_count(err_count),
    .first_err_idx(first_err_idx),
    .err_valid(err_valid)
  );

  always #5 clk = ~clk;

  assign f_sop = (xinj == int'(x_out)) ? 1'bx : sop_tab[x_out];
  assign f_pos = pos_tab[x_out];

  typedef struct {
    string      nm;
    logic [3:0] s;
    logic [3:0] p;
    int         xi;
    int         cnt;
    int         first;
    bit         ev;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: a minterm fails when either implementation disagrees.
  task automatic model(input logic [3:0] s, input logic [3:0] p,
                       output int cnt, output int first);
    cnt = 0;
    first = -1;
    for (int i = 0; i < NV; i++) begin
      if (s[i] !== EXP[i] || p[i] !== EXP[i]) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic run_sweep(input string nm, input logic [3:0] s,
                           input logic [3:0] p, input int xi,
                           input int ecnt, input int efirst,
                           input bit ev, input int pa, input int pb);
    sop_tab = s;
    pos_tab = p;
    xinj = xi;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < NV * (S + 1); k++) begin
      chk({nm, "_x"}, int'(x_out), k / (S + 1));
      chk({nm, "_busy"}, int'(busy), 1);
      if (done || pass) chk({nm, "_done_early"}, int'({done, pass}), 0);
      if (k == pa || k == pb) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk({nm, "_done"}, int'(done), 1);
    chk({nm, "_busy_end"}, int'(busy), 0);
    chk({nm, "_pass"}, int'(pass), (ecnt == 0) ? 1 : 0);
    chk({nm, "_cnt"}, int'(err_count), ecnt);
    chk({nm, "_ev"}, int'(err_valid), int'(ev));
    chk({nm, "_xhold"}, int'(x_out), NV - 1);
    if (ev) chk({nm, "_first"}, int'(first_err_idx), efirst);
    repeat (2) @(posedge clk);
    #1;
    chk({nm, "_hold_done"}, int'(done), 1);
    chk({nm, "_hold_cnt"}, int'(err_count), ecnt);
    xinj = -1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_outs"},
        int'({x_out, busy, done, pass, err_count, first_err_idx, err_valid}),
        0);
  endtask

  vec_t vt[6];

  initial begin
    int cnt;
    int first;
    logic [3:0] rs;
    logic [3:0] rp;

    vt[0] = '{"good", 4'b0101, 4'b0101, -1, 0, 0, 1'b0};
    vt[1] = '{"sop_sa0", 4'b0000, 4'b0101, -1, 2, 0, 1'b1};
    vt[2] = '{"pos_m3", 4'b0101, 4'b1101, -1, 1, 3, 1'b1};
    vt[3] = '{"both_m1", 4'b0111, 4'b0111, -1, 1, 1, 1'b1};
    vt[4] = '{"sop_x_m2", 4'b0101, 4'b0001, 2, 1, 2, 1'b1};
    vt[5] = '{"all_bad", 4'b1010, 4'b1010, -1, 4, 0, 1'b1};

    #1 rst_n = 1'b0;
    #1 chk_all_zero("reset");

    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    chk("first_edge_ignored", int'(busy), 0);
    start = 1'b0;

    foreach (vt[i])
      run_sweep(vt[i].nm, vt[i].s, vt[i].p, vt[i].xi,
                vt[i].cnt, vt[i].first, vt[i].ev, -1, -1);

    run_sweep("restart_ign", EXP, EXP, -1, 0, 0, 1'b0, 2, 5);

    for (int r = 0; r < 16; r++) begin
      rs = 4'($urandom_range(0, 15));
      rp = 4'($urandom_range(0, 15));
      model(rs, rp, cnt, first);
      run_sweep($sformatf("rnd%0d", r), rs, rp, -1,
                cnt, first, cnt != 0, -1, -1);
    end

    sop_tab = 4'b0000;
    pos_tab = EXP;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_cnt", int'(err_count), 2);
    chk("mid_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    chk("rel_first_edge", int'(busy), 0);
    @(posedge clk); #1;
    chk("rel_second_edge", int'(busy), 1);
    chk("rel_cnt_clear", int'(err_count), 0);
    start = 1'b0;
    repeat (NV * (S + 1)) @(posedge clk);
    #1;
    chk("rel_done", int'(done), 1);
    chk("rel_cnt", int'(err_count), 2);
    chk("rel_first", int'(first_err_idx), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
